macc_stream_loader: RTL and testbench

//  Upstream feeder for the matrix accelerator. Accepts a 32-bit valid/ready word stream and writes it into
//  the A, B and C matrix RAMs, in order A, B, C, restricted to the matrices selected at start.

---
 rtl/macc_pkg.sv | 36 +++
 rtl/macc_word_counter.sv | 26 ++
 rtl/macc_stream_loader.sv | 142 ++++++++++++++
 tb/tb_macc_stream_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared types and constants for the matrix accelerator loader and macc.
// Holds the loader state enum, matrix bit indices and RAM sizing constants.
package macc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    DONE
  } state_t;

  localparam int MAT_A = 2;
  localparam int MAT_B = 1;
  localparam int MAT_C = 0;

  localparam int RAM_ADDR_MSB     = 11;
  localparam int MAT_IDX_SIZE_MSB = 3;

  // First matrix still to load, in A, B, C order.
  function automatic state_t first_load(
    input logic [2:0] mask
  );
    state_t s;
    if (mask[MAT_A])
      s = LOAD_A;
    else if (mask[MAT_B])
      s = LOAD_B;
    else if (mask[MAT_C])
      s = LOAD_C;
    else
      s = DONE;
    return s;
  endfunction

endpackage

// File: rtl/macc_word_counter.sv
// Per-matrix word counter; wraps to 0 after WORDS accepted beats.
// Ports: CLK, RST, inc, clr in; count, wrap (inc on last word) out.
module macc_word_counter #(
  parameter int WORDS = 4096,
  parameter int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = inc && (count == CNT_W'(WORDS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/macc_stream_loader.sv
// Streams 32-bit words into the A/B/C matrix RAMs of the accelerator,
// in A, B, C order, restricted to the matrices selected at start.
// Ports: CLK, RST (async, active high), start, load_mask[2:0] (A,B,C),
//   s_valid/s_ready/s_data stream in, s_last (MACC_LOADER_LAST_CHECK_EN),
//   wen_to_macc[2:0], data_to_macc out, busy, done pulse, err (sticky).
// Macro MACC_LOADER_LAST_CHECK_EN adds s_last framing check driving err.
module macc_stream_loader
  import macc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [2:0]        load_mask,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
`ifdef MACC_LOADER_LAST_CHECK_EN
  input  logic              s_last,
`endif
  output logic [2:0]        wen_to_macc,
  output logic [DATA_W-1:0] data_to_macc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       mask_q;
  logic [2:0]       mask_nxt;
  logic [2:0]       cur_bit;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             accept;
  logic             start_ok;

  assign accept   = s_valid && s_ready;
  assign start_ok = start && (state == IDLE);

  macc_word_counter #(
    .WORDS (WORDS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (accept),
    .clr   (start_ok),
    .count (cnt),
    .wrap  (wrap)
  );

  // State decode kept apart from next-state logic so the
  // s_ready -> accept -> wrap path does not loop through one block.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    cur_bit = 3'b000;
    unique case (state)
      LOAD_A: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        cur_bit = 3'(1 << MAT_A);
      end
      LOAD_B: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        cur_bit = 3'(1 << MAT_B);
      end
      LOAD_C: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        cur_bit = 3'(1 << MAT_C);
      end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_nxt  = load_mask;
          state_nxt = first_load(load_mask);
        end
      end
      LOAD_A, LOAD_B, LOAD_C: begin
        // Retire the finished matrix, move on without a bubble.
        if (wrap) begin
          mask_nxt  = mask_q & ~cur_bit;
          state_nxt = first_load(mask_nxt);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      mask_q       <= '0;
      wen_to_macc  <= '0;
      data_to_macc <= '0;
      done         <= 1'b0;
    end else begin
      state       <= state_nxt;
      mask_q      <= mask_nxt;
      wen_to_macc <= accept ? cur_bit : 3'b000;
      if (accept)
        data_to_macc <= s_data;
      // done follows the DONE cycle, so it lands as busy drops.
      done <= (state == DONE);
    end
  end

`ifdef MACC_LOADER_LAST_CHECK_EN
  logic last_word;
  assign last_word = (cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      err <= 1'b0;
    else if (start_ok)
      err <= 1'b0;
    else if (accept && (s_last != last_word))
      err <= 1'b1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_macc_stream_loader.sv
// Randomized bench for macc_stream_loader with WORDS=4.
// Expected writes come from a mask-ordered word list model.
module tb_macc_stream_loader;

  localparam int WORDS = 4;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [2:0]  load_mask;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [2:0]  wen_to_macc;
  logic [31:0] data_to_macc;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  logic [31:0] words[$];
  int          obs_n;
  bit          err_exp;

  macc_stream_loader #(
    .DATA_W (32),
    .WORDS  (WORDS)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .load_mask    (load_mask),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
`ifdef MACC_LOADER_LAST_CHECK_EN
    .s_last       (s_last),
`endif
    .wen_to_macc  (wen_to_macc),
    .data_to_macc (data_to_macc),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Model: each selected matrix, A then B then C, takes the next
  // WORDS stream words; strobe is the matrix's load_mask bit.
  task automatic build(input logic [2:0] m, input bit seq);
    logic [31:0] w;
    int n = 0;
    exp_q.delete();
    words.delete();
    obs_n = 0;
    for (int k = 2; k >= 0; k--)
      if (m[k])
        for (int i = 0; i < WORDS; i++) begin
          n++;
          w = seq ? 32'(n) : $urandom;
          words.push_back(w);
          exp_q.push_back({3'(1 << k), w});
        end
  endtask

  task automatic tick();
    logic acc;
    acc = s_valid && s_ready;
    @(posedge CLK);
    #1;
    chk("strobe_latency", 64'(wen_to_macc != 3'b000), 64'(acc));
    if (wen_to_macc != 3'b000) begin
      if (obs_n < exp_q.size())
        chk("write", 64'({wen_to_macc, data_to_macc}), 64'(exp_q[obs_n]));
      else
        chk("extra_write", 64'(wen_to_macc), 64'd0);
      obs_n++;
    end else if (obs_n > 0 && obs_n <= exp_q.size()) begin
      chk("data_hold", 64'(data_to_macc), 64'(exp_q[obs_n-1][31:0]));
    end
  endtask

  task automatic run_load(input logic [2:0] m, input int mode,
                          input bit seq, input bit poke, input int bad);
    int  idx, cyc, rdy, dcyc, last_acc, total, exp_dc;
    bit  acc, nerr, lw;
    build(m, seq);
    total    = exp_q.size();
    idx      = 0;
    cyc      = 0;
    rdy      = 0;
    dcyc     = -1;
    last_acc = -1;
    start     = 1'b1;
    load_mask = m;
    tick();
    start     = 1'b0;
    load_mask = 3'($urandom);
    err_exp   = 1'b0;
    chk("busy_on_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    while (dcyc < 0 && cyc < 400) begin
      if (mode == 0)
        s_valid = 1'b1;
      else if (mode == 1)
        s_valid = (cyc % 2 == 0);
      else
        s_valid = 1'($urandom_range(0, 1));
      s_data = (idx < total) ? words[idx] : $urandom;
      start  = poke && (idx >= WORDS);
      if (poke)
        load_mask = 3'($urandom);
      acc = s_valid && s_ready;
      lw  = ((idx % WORDS) == WORDS - 1);
      s_last = (idx == bad) ? 1'b1 : lw;
`ifdef MACC_LOADER_LAST_CHECK_EN
      nerr = err_exp | (acc && (s_last != lw));
`else
      nerr = 1'b0;
`endif
      if (s_ready)
        rdy++;
      if (acc) begin
        last_acc = cyc;
        idx++;
      end
      tick();
      cyc++;
      err_exp = nerr;
      chk("err", 64'(err), 64'(err_exp));
      if (done)
        dcyc = cyc;
      else
        chk("busy_during_load", 64'(busy), 64'd1);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_dc  = (total == 0) ? 1 : last_acc + 2;
    chk("done_seen", 64'(dcyc >= 0), 64'd1);
    chk("done_time", 64'(dcyc), 64'(exp_dc));
    chk("busy_with_done", 64'(busy), 64'd0);
    chk("words_written", 64'(obs_n), 64'(total));
    if (mode == 0)
      chk("ready_cycles", 64'(rdy), 64'(total));
    tick();
    chk("done_width", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(s_ready), 64'd0);
    chk("err_hold", 64'(err), 64'(err_exp));
  endtask

  initial begin
    RST       = 1'b1;
    start     = 1'b0;
    load_mask = 3'b000;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    obs_n     = 0;
    err_exp   = 1'b0;
    #12;
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_wen", 64'(wen_to_macc), 64'd0);
    chk("rst_data", 64'(data_to_macc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();

    run_load(3'b111, 0, 1'b1, 1'b0, -1);
    run_load(3'b010, 1, 1'b0, 1'b0, -1);
    run_load(3'b000, 0, 1'b0, 1'b0, -1);

    build(3'b100, 1'b0);
    start     = 1'b1;
    load_mask = 3'b100;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = words[0];
    tick();
    s_data  = words[1];
    tick();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_ready", 64'(s_ready), 64'd0);
    chk("arst_wen", 64'(wen_to_macc), 64'd0);
    chk("arst_data", 64'(data_to_macc), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    s_valid = 1'b0;
    err_exp = 1'b0;
    run_load(3'b100, 0, 1'b0, 1'b0, -1);

    run_load(3'b111, 2, 1'b0, 1'b1, -1);

    run_load(3'b111, 0, 1'b0, 1'b0, 2);
    run_load(3'b100, 2, 1'b0, 1'b0, -1);

    for (int r = 0; r < 6; r++)
      run_load(3'($urandom_range(0, 7)), 2, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
